// File: rtl/alu_sequencer_pkg.sv
// Shared ALU widths and opcode encodings for the ALU front end and its
// neighbours at the execute level.
package alu_sequencer_pkg;

    localparam int aluwidth = 16;
    localparam int opsize   = 3;
    localparam int numflags = 4;

    localparam logic [opsize-1:0] OP_ADD = 3'd0;
    localparam logic [opsize-1:0] OP_SUB = 3'd1;
    localparam logic [opsize-1:0] OP_AND = 3'd2;
    localparam logic [opsize-1:0] OP_OR  = 3'd3;
    localparam logic [opsize-1:0] OP_LS  = 3'd4;
    localparam logic [opsize-1:0] OP_RS  = 3'd5;

    // Shifts are the only opcodes that iterate the ALU more than once.
    function automatic logic is_shift(input logic [opsize-1:0] op);
        return (op == OP_LS) || (op == OP_RS);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Request/response front end for the combinational ALU: holds one operation,
// iterates single-bit shifts, and returns the captured result and flags.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int SHW  = 4,
    parameter int TAGW = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [opsize-1:0]   req_op,
    input  logic [aluwidth-1:0] req_a,
    input  logic [aluwidth-1:0] req_b,
    input  logic [SHW-1:0]      req_shamt,
    input  logic [TAGW-1:0]     req_tag,

    output logic [opsize-1:0]   alu_opcode,
    output logic [aluwidth-1:0] alu_in1,
    output logic [aluwidth-1:0] alu_in2,
    input  logic [aluwidth-1:0] alu_out,
    input  logic [numflags-1:0] alu_flags,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [aluwidth-1:0] rsp_result,
    output logic [numflags-1:0] rsp_flags,
    output logic [TAGW-1:0]     rsp_tag,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SHW-1:0] cnt_one = SHW'(1);

    state_t                state;
    logic [opsize-1:0]     op_r;
    logic [aluwidth-1:0]   acc;
    logic [aluwidth-1:0]   b_r;
    logic [TAGW-1:0]       tag_r;
    logic [SHW-1:0]        cnt;
    logic [numflags-1:0]   flags_r;

    // The ALU always sees registered operands, so its path is one ALU delay.
    assign alu_opcode = op_r;
    assign alu_in1    = acc;
    assign alu_in2    = b_r;

    assign rsp_result = acc;
    assign rsp_flags  = flags_r;
    assign rsp_tag    = tag_r;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the same pre-edge values, including acc feeding back through the ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_r      <= '0;
            acc       <= '0;
            b_r       <= '0;
            tag_r     <= '0;
            cnt       <= '0;
            flags_r   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_r      <= req_op;
                        acc       <= req_a;
                        b_r       <= req_b;
                        tag_r     <= req_tag;
                        // A zero shift count still performs one ALU pass.
                        if (is_shift(req_op) && (req_shamt != '0))
                            cnt <= req_shamt;
                        else
                            cnt <= cnt_one;
                        state     <= EXEC;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                EXEC: begin
                    acc     <= alu_out;
                    flags_r <= alu_flags;
                    cnt     <= cnt - cnt_one;
                    if (cnt == cnt_one) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end

                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random
// transactions compared against a whole-operation arithmetic model.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int SHW  = 4;
    localparam int TAGW = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [opsize-1:0]   req_op;
    logic [aluwidth-1:0] req_a;
    logic [aluwidth-1:0] req_b;
    logic [SHW-1:0]      req_shamt;
    logic [TAGW-1:0]     req_tag;
    logic [opsize-1:0]   alu_opcode;
    logic [aluwidth-1:0] alu_in1;
    logic [aluwidth-1:0] alu_in2;
    logic [aluwidth-1:0] alu_out;
    logic [numflags-1:0] alu_flags;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [aluwidth-1:0] rsp_result;
    logic [numflags-1:0] rsp_flags;
    logic [TAGW-1:0]     rsp_tag;
    logic                busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.SHW(SHW), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .req_tag(req_tag),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy)
    );

    // Stand-in for ALUmodule: single-bit shifts, flags {parity, carry, neg, zero}.
    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_LS:   return x << 1;
            OP_RS:   return x >> 1;
            default: return x;
        endcase
    endfunction

    function automatic logic [3:0] flag_fn(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] wide;
        logic [15:0] o;
        logic        c;
        o = alu_fn(op, x, y);
        wide = {1'b0, x} + {1'b0, y};
        case (op)
            OP_ADD:  c = wide[16];
            OP_SUB:  c = (x < y);
            OP_LS:   c = x[15];
            OP_RS:   c = x[0];
            default: c = 1'b0;
        endcase
        return {^o, c, o[15], (o == 16'h0000)};
    endfunction

    always_comb begin
        alu_out   = alu_fn(alu_opcode, alu_in1, alu_in2);
        alu_flags = flag_fn(alu_opcode, alu_in1, alu_in2);
    end

    // Reference model: whole-operation results, no iteration.
    function automatic int exp_passes(input logic [2:0] op, input logic [3:0] shamt);
        if ((op == OP_LS) || (op == OP_RS))
            return (shamt == 4'd0) ? 1 : int'(shamt);
        return 1;
    endfunction

    function automatic logic [15:0] model_result(input logic [2:0] op, input logic [15:0] a,
                                                 input logic [15:0] b, input logic [3:0] shamt);
        int n;
        n = exp_passes(op, shamt);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_LS:   return a << n;
            OP_RS:   return a >> n;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] model_flags(input logic [2:0] op, input logic [15:0] a,
                                               input logic [15:0] b, input logic [3:0] shamt);
        int n;
        logic [15:0] last_in1;
        n = exp_passes(op, shamt);
        case (op)
            OP_LS:   last_in1 = a << (n - 1);
            OP_RS:   last_in1 = a >> (n - 1);
            default: last_in1 = a;
        endcase
        return flag_fn(op, last_in1, b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] shamt, input logic [3:0] tag);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_shamt = shamt;
        req_tag   = tag;
        req_valid = 1'b1;
    endtask

    // Full transaction: accept, measure latency, hold in DONE for 'stall' cycles, retire.
    task automatic do_txn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] shamt, input logic [3:0] tag, input int stall);
        int guard;
        int cyc;
        logic [15:0] er;
        logic [3:0]  ef;
        er = model_result(op, a, b, shamt);
        ef = model_flags(op, a, b, shamt);
        drive_req(op, a, b, shamt, tag);
        guard = 0;
        while (!req_ready && guard < 40) begin
            tick();
            guard++;
        end
        check("accept_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("latency", cyc, exp_passes(op, shamt) + 1);
        check("result", rsp_result, er);
        check("flags", rsp_flags, ef);
        check("tag", rsp_tag, tag);
        check("busy_done", busy, 1);
        check("ready_done", req_ready, 0);
        rsp_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", rsp_valid, 1);
            check("stall_result", rsp_result, er);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("idle_ready", req_ready, 1);
    endtask

    initial begin
        int seen;
        int guard;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_shamt = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", rsp_result, 0);
        check("rst_flags", rsp_flags, 0);
        check("rst_tag", rsp_tag, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_in1", alu_in1, 0);
        check("rst_in2", alu_in2, 0);

        // ADD overflowing to zero
        do_txn(OP_ADD, 16'h8000, 16'h8000, 4'd0, 4'hA, 0);

        // LS by 4: observe the accumulator chain
        drive_req(OP_LS, 16'h0001, 16'h0000, 4'd4, 4'h3);
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("ls_opcode", alu_opcode, OP_LS);
            check("ls_valid_low", rsp_valid, 0);
            tick();
            check("ls_step", alu_in1, 32'd1 << k);
        end
        check("ls_valid", rsp_valid, 1);
        check("ls_result", rsp_result, 16'h0010);
        check("ls_tag", rsp_tag, 4'h3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // RS with zero shift count is a single pass
        do_txn(OP_RS, 16'h8000, 16'h0000, 4'd0, 4'h1, 0);

        // SUB ignores the shift count
        do_txn(OP_SUB, 16'h0003, 16'h0005, 4'd9, 4'h6, 1);
        check("sub_result_const", rsp_result, 16'hFFFE);

        // Backpressure with a second request waiting
        drive_req(OP_OR, 16'h00F0, 16'h0F00, 4'd0, 4'h5);
        tick();
        drive_req(OP_AND, 16'hFF0F, 16'h0FF0, 4'd0, 4'h9);
        tick();
        check("bp_valid", rsp_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_result", rsp_result, 16'h0FF0);
            check("bp_flags", rsp_flags, model_flags(OP_OR, 16'h00F0, 16'h0F00, 4'd0));
            check("bp_tag", rsp_tag, 4'h5);
            check("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_idle_ready", req_ready, 1);
        check("bp_valid_drop", rsp_valid, 0);
        tick();
        req_valid = 1'b0;
        check("bp_accept_busy", busy, 1);
        check("bp_accept_ready", req_ready, 0);
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            tick();
            guard++;
        end
        check("bp2_result", rsp_result, 16'h0F00);
        check("bp2_tag", rsp_tag, 4'h9);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during the second EXEC cycle of LS by 8
        drive_req(OP_LS, 16'h1234, 16'h0000, 4'd8, 4'h7);
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_in1", alu_in1, 16'h2468);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_in1", alu_in1, 0);
        check("mid_rst_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("mid_no_rsp", seen, 0);

        // Random transactions including undefined opcodes
        for (int t = 0; t < 40; t++) begin
            do_txn(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   4'($urandom_range(0, 15)), 4'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request-driven front end for the combinational ALU. It accepts one operation per valid/ready handshake and drives `opcode`/`in1`/`in2` into `ALUmodule`. It captures `out`/`flags` into registers and returns them through a valid/ready response port. Multi-bit shifts (`LS`/`RS` with a shift amount) run by iterating the ALU's single-bit shift once per cycle. The block sits between instruction decode and register writeback, on the initiator side of the ALU interface.

## Interface
- `aluwidth`, 16: datapath width, from `parameters.v`.
- `opsize`, from `parameters.v`: opcode width.
- `numflags`, from `parameters.v`: flag vector width.
- `SHW`, 4: shift-amount width.
- `TAGW`, 4: request tag width.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_op` input opsize: ALU opcode (`ADD`, `SUB`, `AND`, `OR`, `LS`, `RS`).
- `req_a` input aluwidth: operand 1.
- `req_b` input aluwidth: operand 2.
- `req_shamt` input SHW: shift count, used only for `LS`/`RS`.
- `req_tag` input TAGW: returned unchanged with the result.
- `alu_opcode` output opsize: to `ALUmodule.opcode`.
- `alu_in1` output aluwidth: to `ALUmodule.in1`.
- `alu_in2` output aluwidth: to `ALUmodule.in2`.
- `alu_out` input aluwidth: from `ALUmodule.out`.
- `alu_flags` input numflags: from `ALUmodule.flags`.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer takes the result.
- `rsp_result` output aluwidth: registered result.
- `rsp_flags` output numflags: registered flags from the final ALU pass.
- `rsp_tag` output TAGW: tag of the request.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- **States:** IDLE, EXEC, DONE.
- **IDLE:** `req_ready`=1.
  - On `req_valid`: latch op into `op_r`, `req_a` into `acc`, `req_b` into `b_r`, tag into `tag_r`, and load `cnt`.
  - `cnt` = max(`req_shamt`,1) for `LS`/`RS`; `cnt` = 1 for every other opcode, including undefined ones.
  - Go to EXEC.
- **ALU drive:** `alu_opcode`=`op_r`, `alu_in1`=`acc`, `alu_in2`=`b_r`. These are driven from registers in every state.
- **EXEC:** each cycle, `acc` <= `alu_out`, `flags_r` <= `alu_flags`, `cnt` <= `cnt`-1.
  - When `cnt`==1, go to DONE.
  - For `LS`/`RS` (ALU shifts `in1` by one bit), this chains one bit per cycle. Bits shifted out are lost; no wrap-around.
- **DONE:** `rsp_valid`=1. `rsp_result`=`acc`, `rsp_flags`=`flags_r`, `rsp_tag`=`tag_r`, all held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- **Acceptance:** `req_ready` is 0 outside IDLE, so no request is accepted while one is in flight. A request held valid during DONE is accepted on the first IDLE cycle.
- **Reset:** any state goes to IDLE on the next edge and any in-flight request is dropped.
  - Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `busy`=0, and `rsp_result`, `rsp_flags`, `rsp_tag`, `alu_opcode`, `alu_in1`, `alu_in2` all 0.

## Timing
- Request accepted at edge 0.
- Single-pass op: EXEC during cycle 1; `rsp_valid` first high in cycle 2.
- Shift with n=max(shamt,1): EXEC for n cycles; `rsp_valid` first high in cycle n+1.
- Worst case (shamt=15) is 16 cycles.
- Minimum spacing between accepted requests is 3 cycles (accept, EXEC, DONE with immediate `rsp_ready`).
- Response handshake completes on the edge where `rsp_valid`&&`rsp_ready`. `rsp_valid` drops the next cycle.
- ALU path is combinational from `acc`/`op_r`/`b_r` to the `acc` input. It is one ALU delay per cycle, with no other logic in that path.

## Structure
- Opcode macros and `aluwidth`/`opsize`/`numflags` come from the shared `parameters.v` include. State encodings are local to the block.
- No sub-module. `ALUmodule` is instantiated beside this block at the execute level, not inside it. This keeps the ALU directly testable.

## Test plan
- `ADD`, a=16'h8000, b=16'h8000 -> `rsp_result`=16'h0000, flags equal to the ALU's flags for that pass, `rsp_valid` at cycle 2, `rsp_tag` echoed.
- `LS`, a=16'h0001, shamt=4 -> `alu_opcode`=`LS` for 4 EXEC cycles, `acc` steps 2,4,8,16, `rsp_result`=16'h0010 at cycle 5.
- `RS`, a=16'h8000, shamt=0 -> single pass, `rsp_result`=16'h4000 at cycle 2.
- Backpressure: `rsp_ready` low for 3 cycles in DONE -> result, flags and tag stable, `req_ready`=0 with `req_valid` high. Request accepted the cycle after the response handshake.
- `reset` asserted during the 2nd EXEC cycle of `LS` shamt=8 -> next cycle IDLE, `rsp_valid`=0, `req_ready`=1, `alu_in1`=0. No response is ever issued for the dropped request.
- `SUB`, a=16'h0003, b=16'h0005 with `req_shamt`=9 -> shamt ignored, single pass, `rsp_result`=16'hFFFE.
